mu0_core_param: RTL and testbench

//  Parametrised next-generation MU0 processor core: datapath (IR, Acc, PC, ALU, N/Z flags) plus
//  an integrated fetch/execute control FSM. Talks to memory over a req/ack handshake, so wait-state

---
 rtl/mu0_core_param_if.sv | 34 +++
 rtl/mu0_core_param.sv | 181 ++++++++++++++++++
 tb/tb_mu0_core_param.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mu0_core_param_if.sv
// mu0_core_param_if: req/ack memory bus between the MU0 core and its memory.
// The core drives the request side through the master modport; the memory
// answers through the slave modport. Address width is DATA_W-4, matching the
// address field of an MU0 instruction.
interface mu0_core_param_if #(
    parameter int DATA_W = 16
);
    localparam int ADDR_W = DATA_W - 4;

    logic              Mem_req;
    logic              Mem_wr;
    logic              Mem_ack;
    logic [ADDR_W-1:0] Address;
    logic [DATA_W-1:0] Data_in;
    logic [DATA_W-1:0] Data_out;

    modport master (
        output Mem_req,
        output Mem_wr,
        output Address,
        output Data_out,
        input  Mem_ack,
        input  Data_in
    );

    modport slave (
        input  Mem_req,
        input  Mem_wr,
        input  Address,
        input  Data_out,
        output Mem_ack,
        output Data_in
    );
endinterface

// File: rtl/mu0_core_param.sv
// mu0_core_param: parametrised MU0 core (IR, Acc, PC, ALU, N/Z flags) with an
// integrated fetch/execute FSM talking to memory over a req/ack handshake, so
// wait-state memories are supported.
//
// DATA_W may be 8..32; the opcode is the top 4 bits of an instruction and the
// address is the remaining low DATA_W-4 bits. RESET_PC is truncated to the
// address width.
//
// Optional feature: define MU0_LOGIC_OPS_EN to add AND (8), OR (9) and XOR (10).
// Without it every opcode from 8 to 15 is illegal and halts the core with
// Illegal set.
module mu0_core_param #(
    parameter int DATA_W   = 16,
    parameter int RESET_PC = 0
) (
    input  logic             Clk,
    input  logic             Reset,
    mu0_core_param_if.master mem,
    output logic [3:0]       F,
    output logic             N,
    output logic             Z,
    output logic             Halted,
    output logic             Illegal
);

    localparam int ADDR_W = DATA_W - 4;
    localparam logic [ADDR_W-1:0] PC_AT_RESET = ADDR_W'(RESET_PC);

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_STA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_JMP = 4'h4;
    localparam logic [3:0] OP_JGE = 4'h5;
    localparam logic [3:0] OP_JNE = 4'h6;
    localparam logic [3:0] OP_STP = 4'h7;
`ifdef MU0_LOGIC_OPS_EN
    localparam logic [3:0] OP_AND = 4'h8;
    localparam logic [3:0] OP_OR  = 4'h9;
    localparam logic [3:0] OP_XOR = 4'hA;
`endif

    typedef enum logic [1:0] {
        S_FETCH,
        S_EXEC,
        S_HALT
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt;
    logic [DATA_W-1:0] ir, ir_nxt;
    logic [DATA_W-1:0] acc, acc_nxt;
    logic              illegal_q, illegal_nxt;

    logic [3:0]        opcode;
    logic [ADDR_W-1:0] ir_addr;
    logic              is_read;
    logic              is_write;
    logic              is_logic;
    logic [DATA_W-1:0] alu_res;
    logic              req;
    logic              wr;

    assign opcode  = ir[DATA_W-1 -: 4];
    assign ir_addr = ir[ADDR_W-1:0];

`ifdef MU0_LOGIC_OPS_EN
    assign is_logic = (opcode == OP_AND) || (opcode == OP_OR) || (opcode == OP_XOR);
`else
    assign is_logic = 1'b0;
`endif

    assign is_read  = (opcode == OP_LDA) || (opcode == OP_ADD) ||
                      (opcode == OP_SUB) || is_logic;
    assign is_write = (opcode == OP_STA);

    // Accumulator result for the memory-read opcodes (modulo 2^DATA_W).
    always_comb begin
        alu_res = mem.Data_in;
        case (opcode)
            OP_ADD:  alu_res = acc + mem.Data_in;
            OP_SUB:  alu_res = acc - mem.Data_in;
`ifdef MU0_LOGIC_OPS_EN
            OP_AND:  alu_res = acc & mem.Data_in;
            OP_OR:   alu_res = acc | mem.Data_in;
            OP_XOR:  alu_res = acc ^ mem.Data_in;
`endif
            default: alu_res = mem.Data_in;
        endcase
    end

    // Next state, register updates and bus controls for fetch/execute/halt.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can leave a latch.
        state_nxt   = state;
        pc_nxt      = pc;
        ir_nxt      = ir;
        acc_nxt     = acc;
        illegal_nxt = illegal_q;
        req         = 1'b0;
        wr          = 1'b0;

        case (state)
            S_FETCH: begin
                req = 1'b1;
                if (mem.Mem_ack) begin
                    ir_nxt    = mem.Data_in;
                    pc_nxt    = pc + ADDR_W'(1);
                    state_nxt = S_EXEC;
                end
            end

            S_EXEC: begin
                if (is_read || is_write) begin
                    // Memory opcodes keep the request up until the memory acknowledges.
                    req = 1'b1;
                    wr  = is_write;
                    if (mem.Mem_ack) begin
                        state_nxt = S_FETCH;
                        if (is_read) begin
                            acc_nxt = alu_res;
                        end
                    end
                end else begin
                    // Jumps, STP and illegal opcodes finish in this single cycle.
                    state_nxt = S_FETCH;
                    case (opcode)
                        OP_JMP: pc_nxt = ir_addr;
                        OP_JGE: if (!acc[DATA_W-1]) pc_nxt = ir_addr;
                        OP_JNE: if (acc != '0) pc_nxt = ir_addr;
                        OP_STP: state_nxt = S_HALT;
                        default: begin
                            state_nxt   = S_HALT;
                            illegal_nxt = 1'b1;
                        end
                    endcase
                end
            end

            S_HALT: begin
                state_nxt = S_HALT;
            end

            default: begin
                state_nxt = S_FETCH;
            end
        endcase
    end

    // FSM state and architectural registers; synchronous active-low reset.
    always_ff @(posedge Clk) begin
        // NOTE: non-blocking assignments make every register see pre-edge values of the others.
        if (!Reset) begin
            state     <= S_FETCH;
            pc        <= PC_AT_RESET;
            ir        <= '0;
            acc       <= '0;
            illegal_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            ir        <= ir_nxt;
            acc       <= acc_nxt;
            illegal_q <= illegal_nxt;
        end
    end

    // Request is masked by reset so an in-flight transfer is dropped at once
    // and no transfer can complete on a reset edge.
    assign mem.Mem_req  = req & Reset;
    assign mem.Mem_wr   = wr;
    assign mem.Address  = (state == S_FETCH) ? pc : ir_addr;
    assign mem.Data_out = acc;

    assign F       = opcode;
    assign N       = acc[DATA_W-1];
    assign Z       = (acc == '0);
    assign Halted  = (state == S_HALT);
    assign Illegal = illegal_q;

endmodule

// File: tb/tb_mu0_core_param.sv
// tb_mu0_core_param: self-checking bench for mu0_core_param (DATA_W=16,
// RESET_PC=12'h100). Directed programs plus randomized programs with random
// wait states, compared against an instruction-level model of the MU0 ISA.
module tb_mu0_core_param;

    localparam int          DW     = 16;
    localparam int          AW     = 12;
    localparam int          RST_PC = 'h100;
`ifdef MU0_LOGIC_OPS_EN
    localparam bit          LOGIC_EN = 1'b1;
`else
    localparam bit          LOGIC_EN = 1'b0;
`endif

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          wr;
        logic [DW-1:0] data;
    } xfer_t;

    logic       clk;
    logic       Reset;
    logic [3:0] F;
    logic       N;
    logic       Z;
    logic       Halted;
    logic       Illegal;

    mu0_core_param_if #(.DATA_W(DW)) mif();

    mu0_core_param #(
        .DATA_W   (DW),
        .RESET_PC (RST_PC)
    ) dut (
        .Clk     (clk),
        .Reset   (Reset),
        .mem     (mif),
        .F       (F),
        .N       (N),
        .Z       (Z),
        .Halted  (Halted),
        .Illegal (Illegal)
    );

    // Memory seen by the DUT, the image to load, and the model's own copy.
    logic [DW-1:0] tb_mem  [0:4095];
    logic [DW-1:0] img     [0:4095];
    logic [DW-1:0] mdl_mem [0:4095];

    assign mif.Data_in = tb_mem[mif.Address];

    int    n_checks = 0;
    int    n_fail   = 0;
    int    ack_mode = 0;       // 0: ack tied high, 1: random ack, 2: ack held low
    xfer_t act_q[$];
    xfer_t exp_q[$];
    bit    exp_halt;
    bit    exp_ill;
    int    exp_acc;
    int    exp_op;
    int    n_instr;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory side: drive Mem_ack after each edge, then just before the next
    // edge record completed transfers, perform writes and check stability.
    initial begin : bus_side
        logic        prev_wait;
        logic        prev_rst;
        logic [29:0] prev_sig;
        logic [29:0] cur_sig;
        prev_wait   = 1'b0;
        prev_rst    = 1'b0;
        prev_sig    = '0;
        mif.Mem_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ack_mode)
                0:       mif.Mem_ack = 1'b1;
                1:       mif.Mem_ack = 1'($urandom_range(0, 1));
                default: mif.Mem_ack = 1'b0;
            endcase
            @(negedge clk);
            #4;
            cur_sig = {mif.Mem_req, mif.Address, mif.Mem_wr, mif.Data_out};
            if (prev_wait && prev_rst && Reset) check("hold", cur_sig, prev_sig);
            if (mif.Mem_req && mif.Mem_ack) begin
                act_q.push_back(xfer_t'{mif.Address, mif.Mem_wr,
                                        mif.Mem_wr ? mif.Data_out : mif.Data_in});
                if (mif.Mem_wr) tb_mem[mif.Address] = mif.Data_out;
            end
            prev_wait = mif.Mem_req && !mif.Mem_ack;
            prev_sig  = cur_sig;
            prev_rst  = Reset;
        end
    end

    // Instruction-level MU0 model: runs the program in mdl_mem and lists the
    // memory transfers it must produce, plus the final architectural state.
    task automatic run_model(input int max_instr);
        int            pc;
        int            acc;
        int            op;
        int            a;
        int            m;
        logic [DW-1:0] ir;
        pc = RST_PC;
        acc = 0;
        exp_q.delete();
        exp_halt = 1'b0;
        exp_ill  = 1'b0;
        n_instr  = 0;
        exp_op   = 0;
        while (!exp_halt && n_instr < max_instr) begin
            ir = mdl_mem[pc];
            exp_q.push_back(xfer_t'{12'(pc), 1'b0, ir});
            pc = (pc + 1) % 4096;
            n_instr++;
            op = int'(ir[15:12]);
            a  = int'(ir[11:0]);
            m  = int'(mdl_mem[a]);
            exp_op = op;
            if (op == 1) begin
                mdl_mem[a] = 16'(acc);
                exp_q.push_back(xfer_t'{12'(a), 1'b1, 16'(acc)});
            end else if (op == 4) begin
                pc = a;
            end else if (op == 5) begin
                if (acc < 32768) pc = a;
            end else if (op == 6) begin
                if (acc != 0) pc = a;
            end else if (op == 7) begin
                exp_halt = 1'b1;
            end else if (op == 0 || op == 2 || op == 3 || (LOGIC_EN && op >= 8 && op <= 10)) begin
                exp_q.push_back(xfer_t'{12'(a), 1'b0, 16'(m)});
                case (op)
                    0:       acc = m;
                    2:       acc = (acc + m) % 65536;
                    3:       acc = (acc - m + 65536) % 65536;
                    8:       acc = acc & m;
                    9:       acc = acc | m;
                    default: acc = acc ^ m;
                endcase
            end else begin
                exp_halt = 1'b1;
                exp_ill  = 1'b1;
            end
        end
        exp_acc = acc;
    endtask

    task automatic fill_img_random();
        for (int i = 0; i < 4096; i++) img[i] = 16'($urandom);
    endtask

    // Assert reset, load the image while the core is held, check reset state, release.
    task automatic do_reset();
        @(negedge clk);
        #1;
        Reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4096; i++) begin
            tb_mem[i]  = img[i];
            mdl_mem[i] = img[i];
        end
        @(negedge clk);
        check("rst_req", mif.Mem_req, 0);
        check("rst_addr", mif.Address, RST_PC);
        check("rst_acc", mif.Data_out, 0);
        check("rst_flags", {Halted, Illegal, N, Z, F}, 8'b0001_0000);
        #1;
        act_q.delete();
        Reset = 1'b1;
    endtask

    // Run one program from reset and compare the DUT against the model.
    task automatic run_program(input int mode, input int max_instr);
        int cycles;
        ack_mode = mode;
        do_reset();
        run_model(max_instr);
        cycles = 0;
        forever begin
            @(negedge clk);
            cycles++;
            if (exp_halt ? Halted : (act_q.size() >= exp_q.size())) break;
            if (cycles >= 1500) begin
                if (exp_halt) check("timeout_halt", Halted, 1);
                else          check("timeout_xfers", act_q.size(), exp_q.size());
                break;
            end
        end
        if (exp_halt) begin
            repeat (3) @(negedge clk);
            check("n_xfer", act_q.size(), exp_q.size());
            check("halted", Halted, 1);
            check("illegal", Illegal, exp_ill);
            check("acc", mif.Data_out, exp_acc);
            check("nz", {N, Z}, {exp_acc >= 32768, exp_acc == 0});
            check("f", F, exp_op);
            check("halt_req", mif.Mem_req, 0);
            if (mode == 0) check("cycles", cycles, 2 * n_instr);
        end
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
            check($sformatf("xfer%0d", i), act_q[i], exp_q[i]);
    endtask

    function automatic xfer_t act_at(input int i);
        return (i < act_q.size()) ? act_q[i] : xfer_t'('0);
    endfunction

    initial begin : main
        int            n_wr;
        int            r;
        int            op;
        int            a;
        logic [AW-1:0] t4_addr [10];
        Reset = 1'b0;

        // LDA of a negative value, then STP.
        fill_img_random();
        img['h100] = 16'h0005;
        img['h101] = 16'h7000;
        img['h005] = 16'h8000;
        run_program(0, 20);
        check("t1_acc", mif.Data_out, 16'h8000);
        check("t1_nz", {N, Z}, 2'b10);
        check("t1_pc", act_at(2).addr, 12'h101);

        // LDA 5; ADD 6; STA 7; STP with a wrap to zero.
        fill_img_random();
        img['h100] = 16'h0005;
        img['h101] = 16'h2006;
        img['h102] = 16'h1007;
        img['h103] = 16'h7000;
        img['h005] = 16'hFFFF;
        img['h006] = 16'h0001;
        run_program(0, 20);
        check("t2_write", act_at(5), xfer_t'{12'h007, 1'b1, 16'h0000});
        check("t2_z", Z, 1);

        // Fetch stalled for three edges, then acknowledged on the fourth.
        fill_img_random();
        img['h100] = 16'h4120;
        img['h120] = 16'h7000;
        ack_mode = 2;
        do_reset();
        for (int e = 1; e <= 3; e++) begin
            @(negedge clk);
            check("t3_bus", {mif.Mem_req, mif.Mem_wr, mif.Address}, {1'b1, 1'b0, 12'h100});
            check("t3_f", F, 0);
            if (e == 2) ack_mode = 0;
        end
        @(negedge clk);
        check("t3_f_loaded", F, 4'h4);

        // Conditional jumps on Z and N.
        fill_img_random();
        img['h100] = 16'h0200;
        img['h101] = 16'h6109;
        img['h102] = 16'h0201;
        img['h103] = 16'h6109;
        img['h109] = 16'h0202;
        img['h10A] = 16'h5120;
        img['h10B] = 16'h7000;
        img['h200] = 16'h0000;
        img['h201] = 16'h0001;
        img['h202] = 16'h8000;
        run_program(1, 40);
        t4_addr = '{12'h100, 12'h200, 12'h101, 12'h102, 12'h201,
                    12'h103, 12'h109, 12'h202, 12'h10A, 12'h10B};
        for (int i = 0; i < 10; i++) check("t4_addr", act_at(i).addr, t4_addr[i]);

        // PC wraps from 12'hFFF to 0.
        fill_img_random();
        img['h100] = 16'h4FFF;
        img['hFFF] = 16'h0200;
        img['h000] = 16'h7000;
        run_program(0, 20);
        check("t5_wrap", act_at(3).addr, 12'h000);

        // Illegal opcode 4'hB.
        fill_img_random();
        img['h100] = 16'hB123;
        run_program(0, 20);
        check("t6_ill", {Halted, Illegal, act_q.size() == 1}, 3'b111);

        // Opcode 8 (AND when enabled, illegal otherwise).
        fill_img_random();
        img['h100] = 16'h0200;
        img['h101] = 16'h8201;
        img['h102] = 16'h7000;
        img['h200] = 16'h0FF0;
        img['h201] = 16'h00F0;
        run_program(1, 20);
        if (LOGIC_EN) check("t6_and", {Illegal, mif.Data_out}, {1'b0, 16'h00F0});
        else          check("t6_and", {Illegal, mif.Data_out}, {1'b1, 16'h0FF0});

        // Reset asserted during a wait-stated STA: no write may happen.
        fill_img_random();
        img['h100] = 16'h0200;
        img['h101] = 16'h1300;
        img['h200] = 16'h1234;
        img['h300] = 16'hABCD;
        ack_mode = 0;
        do_reset();
        @(negedge clk);
        @(negedge clk);
        ack_mode = 2;
        repeat (2) begin
            @(negedge clk);
            check("t6_sta_bus", {mif.Mem_req, mif.Mem_wr, mif.Address, mif.Data_out},
                  {1'b1, 1'b1, 12'h300, 16'h1234});
        end
        #1;
        Reset       = 1'b0;
        mif.Mem_ack = 1'b1;
        @(negedge clk);
        check("t6_rst_req", mif.Mem_req, 0);
        @(negedge clk);
        n_wr = 0;
        foreach (act_q[i]) if (act_q[i].wr) n_wr++;
        check("t6_no_write", {n_wr, tb_mem['h300]}, {32'd0, 16'hABCD});

        // Randomized programs with random wait states.
        for (int t = 0; t < 30; t++) begin
            fill_img_random();
            for (int i = 0; i < 32; i++)
                img['h200 + i] = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 2))
                                                               : 16'($urandom);
            for (int i = 0; i < 32; i++) begin
                r = int'($urandom_range(0, 99));
                if (r < 35)      op = (r % 3 == 0) ? 0 : ((r % 3 == 1) ? 2 : 3);
                else if (r < 50) op = 1;
                else if (r < 58) op = 8 + (r % 3);
                else if (r < 85) op = 4 + (r % 3);
                else if (r < 90) op = 7;
                else             op = int'($urandom_range(11, 15));
                if (op >= 4 && op <= 6) a = 'h100 + int'($urandom_range(0, 31));
                else                    a = 'h200 + int'($urandom_range(0, 31));
                img['h100 + i] = 16'((op << 12) | a);
            end
            run_program(int'($urandom_range(0, 1)), 60);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
